// File: rtl/onchip_ram_stream_reader.sv
// Reads word_count consecutive words from an Avalon-MM slave and replays them on a valid/ready stream.
// Reads are throttled so the FIFO always has room for every outstanding response.
module onchip_ram_stream_reader #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [DATA_W-1:0] src_data,
    output logic              src_valid,
    input  logic              src_ready
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]  DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);
    localparam logic [ADDR_W:0] ONE_W   = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t r_state, w_next_state;

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_word_count, r_issued, r_beats;
    logic [CNT_W-1:0]  r_fifo_count, r_pending;
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic              r_done;

    logic              w_start_ok, w_read, w_accept, w_push, w_pop;
    logic              w_last_accept, w_last_beat;
    logic [CNT_W:0]    w_inflight;

    // Every accepted read already owns a FIFO slot, so responses can never overflow it.
    assign w_start_ok    = start && (r_state == IDLE);
    assign w_inflight    = {1'b0, r_fifo_count} + {1'b0, r_pending};
    assign w_read        = (r_state == ISSUE) && (r_issued < r_word_count) && (w_inflight < DEPTH_C);
    assign w_accept      = w_read && !avm_waitrequest;
    assign w_push        = avm_readdatavalid && (r_state != IDLE);
    assign w_pop         = src_valid && src_ready;
    assign w_last_accept = w_accept && ((r_issued + ONE_W) == r_word_count);
    assign w_last_beat   = w_pop && (r_state != IDLE) && ((r_beats + ONE_W) == r_word_count);

    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign avm_read    = w_read;
    assign avm_address = r_addr;
    assign src_valid   = (r_fifo_count != '0);
    assign src_data    = src_valid ? r_mem[r_rd_ptr] : '0;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_start_ok && (word_count != '0)) w_next_state = ISSUE;
            ISSUE: begin
                if (w_last_beat)        w_next_state = IDLE;
                else if (w_last_accept) w_next_state = DRAIN;
            end
            DRAIN:   if (w_last_beat) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_done       <= 1'b0;
            r_addr       <= '0;
            r_word_count <= '0;
            r_issued     <= '0;
            r_beats      <= '0;
            r_pending    <= '0;
            r_fifo_count <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
        end else begin
            r_state <= w_next_state;
            r_done  <= (w_start_ok && (word_count == '0)) || w_last_beat;
            if (w_start_ok) begin
                r_addr       <= base_addr;
                r_word_count <= word_count;
                r_issued     <= '0;
                r_beats      <= '0;
            end else begin
                if (w_accept) begin
                    r_addr   <= r_addr + ADDR_W'(1);
                    r_issued <= r_issued + ONE_W;
                end
                if (w_pop) r_beats <= r_beats + ONE_W;
            end
            if (w_accept && !w_push)      r_pending <= r_pending + CNT_W'(1);
            else if (!w_accept && w_push) r_pending <= r_pending - CNT_W'(1);
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_fifo_count <= r_fifo_count + CNT_W'(1);
            else if (!w_push && w_pop) r_fifo_count <= r_fifo_count - CNT_W'(1);
        end
    end

    // Storage needs no reset: src_data is gated by src_valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= avm_readdata;
    end
endmodule
